mem_arbiter: RTL
================

# mem_arbiter

Shares a single-ported unified memory between the instruction-fetch port (F stage) and the data port (M stage) of the pipelined RISC-V core beneath `top`. It arbitrates requests, drives a req/ready handshake to the backing memory, and returns registered read data. It also exports stall terms that the hazard unit uses to freeze the F and M stages while a port waits.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (macro-gated)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `i_req`  in  1  fetch request
- `i_addr`  in  ADDR_W  fetch address
- `i_rdata`  out  DATA_W  fetch read data, valid when `i_ready`
- `i_ready`  out  1  fetch completion pulse
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address (ALUResultM)
- `d_wdata`  in  DATA_W  store data (WriteDataM)
- `d_rdata`  out  DATA_W  load data, valid when `d_ready`
- `d_ready`  out  1  data completion pulse
- `mem_req`  out  1  backing-memory request
- `mem_we`  out  1  backing-memory write enable
- `mem_addr`  out  ADDR_W  backing-memory address
- `mem_wdata`  out  DATA_W  backing-memory write data
- `mem_rdata`  in  DATA_W  backing-memory read data, valid with `mem_ready`
- `mem_ready`  in  1  backing-memory completion, any latency ≥ 0 cycles after `mem_req`
- `stall_f`  out  1  `i_req & ~i_ready`, combinational
- `stall_m`  out  1  `d_req & ~d_ready`, combinational

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: if `d_req`, latch `d_we/d_addr/d_wdata` and go to BUSY_D. Otherwise, if `i_req`, latch `i_addr` with we=0 and go to BUSY_I. Otherwise stay in IDLE.
- Simultaneous `i_req` and `d_req`: data wins. Exception: the starvation guard can force fetch to win (see Configuration).
- BUSY_x: `mem_req`=1 and `mem_we/addr/wdata` come from the latched registers, stable for the whole state. On `mem_ready`, capture `mem_rdata` and go to RESP.
- RESP: pulse `x_ready`=1 for exactly one cycle with `x_rdata` valid. For a store, `d_rdata` holds the captured value, which is don't-care. Requests are not sampled in RESP. Next state is IDLE.
- Requesters hold `req` and operands stable until their ready pulse. A `req` still high in IDLE after RESP is treated as a new transaction.
- `mem_ready` outside BUSY_x is ignored.
- `x_rdata` holds its value until the next capture.

## Timing
- Reset values: state IDLE, all ready pulses 0, `mem_req` 0, `mem_we` 0, `mem_addr`/`mem_wdata`/`i_rdata`/`d_rdata` 0, starvation counter 0.
- Outputs are registered, except `stall_f` and `stall_m`.
- Minimum latency, with `mem_ready` in the first BUSY cycle:
  - Request is sampled in IDLE at cycle 0.
  - `mem_req`=1 at cycle 1.
  - `x_ready`=1 at cycle 2.
  - IDLE again at cycle 3.
- Each cycle of memory wait adds one cycle to that latency.
- Peak throughput: one transaction per 3 cycles.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and asynchronously, and `mem_req` drops in the same cycle. The pending access is abandoned with no ready pulse. The memory must tolerate a withdrawn request.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each data grant made while `i_req`=1.
  - The counter clears on any fetch grant, and whenever `i_req`=0 in IDLE.
  - When the counter equals `STARVE_MAX`, the next IDLE arbitration grants fetch even if `d_req`=1.
  - The counter saturates at `STARVE_MAX`.
- Undefined: strict data priority, and no counter logic is generated.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum for IDLE, BUSY_I, BUSY_D, RESP.
  - `arb_grant_t` enum for GNT_NONE, GNT_I, GNT_D.
  - Default `STARVE_MAX` constant.
- Optional sub-module `arb_starve_ctr`: the saturating counter with clear and increment inputs and an `at_max` output. It is instantiated only under `MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- Lone fetch: `i_req`=1, `i_addr`=0x10; memory returns 0x00500113 with zero wait → `i_ready`=1 at cycle 2 with `i_rdata`=0x00500113, and `stall_f`=1 during cycles 0–1.
- Store: `d_req`=1, `d_we`=1, `d_addr`=76, `d_wdata`=49, memory waits 2 cycles → `mem_we`=1, `mem_addr`=76, `mem_wdata`=49 held for 3 cycles, then `d_ready` pulses once.
- Simultaneous requests: `i_req`=`d_req`=1 → data is served first; fetch is granted in the IDLE cycle after the data RESP.
- Starvation guard, with macro defined and `STARVE_MAX`=4: `d_req` held high with back-to-back loads and `i_req`=1 → the 5th grant is fetch. With the macro undefined, fetch is never granted while `d_req`=1.
- Reset mid-BUSY_D: assert `reset` while `mem_req`=1 → `mem_req` is 0 in the same cycle, and no `d_ready` pulse occurs after release.
- Spurious `mem_ready` in IDLE → no ready pulse and no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the unified-memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} arb_grant_t;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of data grants made while fetch is waiting
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);
  localparam int W = $clog2(MAX + 2);
  logic [W-1:0] cnt_q, cnt_d;
  assign at_max = cnt_q == W'(MAX);
  // clear wins over increment; hold once saturated
  always_comb cnt_d = clr ? '0 : (inc && !at_max) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data; data has
// priority unless MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_m
);
  arb_state_t state_q, state_d;
  arb_grant_t gnt, gnt_q;
  logic              we_q, busy, force_i;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic at_max;
  arb_starve_ctr #(.MAX(STARVE_MAX)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == IDLE && (gnt == GNT_I || !i_req)),
    .inc   (state_q == IDLE && gnt == GNT_D && i_req),
    .at_max(at_max)
  );
  assign force_i = at_max & i_req;
`else
  assign force_i = STARVE_MAX < 0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  // arbitration and next state; gnt only matters while in IDLE
  always_comb begin
    gnt = (d_req && !force_i) ? GNT_D : i_req ? GNT_I : GNT_NONE;
    state_d = state_q;
    case (state_q)
      IDLE:           state_d = gnt == GNT_D ? BUSY_D : gnt == GNT_I ? BUSY_I : IDLE;
      BUSY_I, BUSY_D: state_d = mem_ready ? RESP : state_q;
      default:        state_d = IDLE;
    endcase
  end

  // latch the granted request's operands and capture returned read data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gnt_q     <= GNT_NONE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && gnt != GNT_NONE) begin
        gnt_q  <= gnt;
        we_q   <= gnt == GNT_D && d_we;
        addr_q <= gnt == GNT_D ? d_addr : i_addr;
        if (gnt == GNT_D) wdata_q <= d_wdata;
      end
      if (state_q == BUSY_I && mem_ready) i_rdata_q <= mem_rdata;
      if (state_q == BUSY_D && mem_ready) d_rdata_q <= mem_rdata;
    end

  // outputs decoded from registered state; only the stalls see live requests
  always_comb begin
    busy      = state_q == BUSY_I || state_q == BUSY_D;
    mem_req   = busy;
    mem_we    = busy & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_ready   = state_q == RESP && gnt_q == GNT_I;
    d_ready   = state_q == RESP && gnt_q == GNT_D;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    stall_f   = i_req & ~i_ready;
    stall_m   = d_req & ~d_ready;
  end
endmodule
